result_writeback: RTL and testbench
===================================

// Module: result_writeback
// PURPOSE
//  Final stage of the output path: consumes the row-vector stream produced by the activation stage
//  and writes each vector into the result BRAM at a strided address. Counts vectors, raises a done
//  flag when the programmed count is written, and flags vectors that arrive outside an active run.
// PARAMETERS
//  MAT_MUL_SIZE  4   lanes per vector (matches `MAT_MUL_SIZE)
//  DWIDTH        8   bits per lane (matches `DWIDTH)
//  AWIDTH        10  result BRAM address width (matches `AWIDTH)
//  MASK_WIDTH    4   lane validity mask width, == MAT_MUL_SIZE
//  CWIDTH        8   vector-count width
// PORTS
//  clk                  in   1                    clock, single domain
//  reset                in   1                    synchronous, active-high
//  enable_writeback     in   1                    level; high = run armed, low = return to IDLE
//  address_c            in   AWIDTH               first write address, sampled on enable rise
//  address_stride_c     in   AWIDTH               address increment per vector, sampled on enable rise
//  num_vectors          in   CWIDTH               vectors to write this run, sampled on enable rise
//  in_data_available    in   1                    valid for inp_data (no backpressure path)
//  inp_data             in   MAT_MUL_SIZE*DWIDTH  lane 0 in bits [DWIDTH-1:0]
//  validity_mask        in   MASK_WIDTH           bit i = lane i valid
//  bram_addr_c          out  AWIDTH               write address
//  bram_wdata_c         out  MAT_MUL_SIZE*DWIDTH  write data
//  bram_we_c            out  MASK_WIDTH           per-lane write enable
//  done_writeback       out  1                    high in DONE
//  overrun_error        out  1                    sticky: vector arrived while not ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, address/count registers 0.
//  - States: IDLE -> (enable rise) LOAD -> ACTIVE -> (count==num_vectors) DONE -> (enable low) IDLE.
//  - LOAD (1 cycle): latch address_c, address_stride_c, num_vectors; count=0. Vectors arriving in LOAD
//    are written normally (LOAD behaves as ACTIVE for data), so no vector is lost on the rise edge.
//  - num_vectors==0: LOAD -> DONE directly; no writes.
//  - Write: in_data_available in LOAD/ACTIVE -> next cycle bram_we_c=validity_mask, bram_addr_c=cur_addr,
//    bram_wdata_c=inp_data (latency exactly 1, registered). we=0 in every other cycle; addr/wdata hold.
//  - Each accepted vector: cur_addr += stride (mod 2^AWIDTH, wraps silently); count += 1.
//  - Accepting vector number num_vectors moves to DONE in the same edge; done_writeback high the cycle
//    that final write is presented and stays high until enable_writeback low.
//  - validity_mask==0 on a valid beat: counted and address advanced, bram_we_c=0.
//  - in_data_available in IDLE or DONE: data dropped, overrun_error set; cleared only by reset or
//    enable rise (LOAD).
//  - enable_writeback low mid-run: next state IDLE, count discarded; a write registered in that
//    same edge still completes; done_writeback never asserts for the aborted run.
//  - reset mid-run overrides everything, including a pending write (bram_we_c=0 next cycle).
// STRUCTURE
//  - Shared package/defines: state encoding (IDLE/LOAD/ACTIVE/DONE), lane width/count macros.
//  - Single module; optional sub-module wb_addr_gen (start/stride latch, increment, wrap) if reused
//    for the matrix-A/B read paths.
// TESTING
//  - Reset: assert reset mid-ACTIVE with valid high -> next cycle bram_we_c=0, done=0, overrun=0.
//  - address_c=0x010, stride=4, num_vectors=3, 3 back-to-back vectors -> writes at 0x010,0x014,0x018,
//    we=4'hF, done high with 3rd write, stays high until enable low.
//  - Gapped input (valid every 3rd cycle), num_vectors=2 -> exactly 2 writes, each 1 cycle after valid.
//  - address_c=0x3FE, stride=1, num_vectors=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
//  - mask=4'b0101 then 4'b0000 -> we=4'b0101 then we=0 with address still advancing by stride.
//  - num_vectors=0 -> done 2 cycles after enable rise, no writes; valid in DONE -> overrun_error=1.

Source files
------------

// File: rtl/result_writeback_pkg.sv
// Shared constants for the result write-back path: state encoding and default geometry.
package result_writeback_pkg;

  localparam int unsigned MAT_MUL_SIZE_DEF = 4;
  localparam int unsigned DWIDTH_DEF       = 8;
  localparam int unsigned AWIDTH_DEF       = 10;
  localparam int unsigned MASK_WIDTH_DEF   = MAT_MUL_SIZE_DEF;
  localparam int unsigned CWIDTH_DEF       = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/result_writeback_addr_gen.sv
// Strided address generator: latches start/stride on load, advances by stride per accepted beat.
module result_writeback_addr_gen #(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [AWIDTH-1:0] stride,
  output logic [AWIDTH-1:0] addr
);

  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH-1:0] stride_q;

  // During load the start address is used directly so a beat in that cycle is not lost.
  always_comb begin
    addr = load ? start_addr : cur_addr;
  end

  // Latch run geometry on load; step by stride (wrapping modulo 2^AWIDTH) on each advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr <= '0;
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
      cur_addr <= advance ? start_addr + stride : start_addr;
    end else if (advance) begin
      cur_addr <= cur_addr + stride_q;
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Result write-back stage: writes row vectors into the result BRAM at strided addresses,
// counts them against a programmed total, and flags vectors arriving outside a run.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int unsigned MAT_MUL_SIZE = MAT_MUL_SIZE_DEF,
  parameter int unsigned DWIDTH       = DWIDTH_DEF,
  parameter int unsigned AWIDTH       = AWIDTH_DEF,
  parameter int unsigned MASK_WIDTH   = MASK_WIDTH_DEF,
  parameter int unsigned CWIDTH       = CWIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_writeback,
  input  logic [AWIDTH-1:0]              address_c,
  input  logic [AWIDTH-1:0]              address_stride_c,
  input  logic [CWIDTH-1:0]              num_vectors,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [AWIDTH-1:0]              bram_addr_c,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c,
  output logic [MASK_WIDTH-1:0]          bram_we_c,
  output logic                           done_writeback,
  output logic                           overrun_error
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              enable_d;
  logic              enable_rise;
  logic [CWIDTH-1:0] count;
  logic [CWIDTH-1:0] num_q;
  logic [CWIDTH-1:0] num_eff;
  logic [CWIDTH-1:0] count_inc;
  logic              is_load;
  logic              taking;
  logic              accept;
  logic              last;
  logic [AWIDTH-1:0] wr_addr;

  result_writeback_addr_gen #(
    .AWIDTH(AWIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (is_load),
    .advance   (accept),
    .start_addr(address_c),
    .stride    (address_stride_c),
    .addr      (wr_addr)
  );

  // LOAD takes data like ACTIVE, using the live run parameters since they latch on that edge.
  always_comb begin
    enable_rise = enable_writeback && !enable_d;
    is_load     = (state == S_LOAD);
    taking      = is_load || (state == S_ACTIVE);
    num_eff     = is_load ? num_vectors : num_q;
    count_inc   = (is_load ? '0 : count) + CWIDTH'(1);
    accept      = in_data_available && taking && (num_eff != '0);
    last        = accept && (count_inc == num_eff);
  end

  // Next-state selection; dropping enable always wins so an aborted run never reaches DONE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (enable_rise) state_next = S_LOAD;
      S_LOAD: begin
        if (!enable_writeback)     state_next = S_IDLE;
        else if (num_vectors == '0) state_next = S_DONE;
        else if (last)             state_next = S_DONE;
        else                       state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!enable_writeback) state_next = S_IDLE;
        else if (last)         state_next = S_DONE;
      end
      default:  if (!enable_writeback) state_next = S_IDLE;
    endcase
  end

  // State, enable edge history, run length latch and accepted-vector count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      enable_d <= 1'b0;
      count    <= '0;
      num_q    <= '0;
    end else begin
      state    <= state_next;
      enable_d <= enable_writeback;
      if (is_load) begin
        num_q <= num_vectors;
        count <= accept ? CWIDTH'(1) : '0;
      end else if (accept) begin
        count <= count_inc;
      end
    end
  end

  // Registered BRAM write port: one-cycle latency, enables pulse only for accepted beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_we_c    <= '0;
      bram_addr_c  <= '0;
      bram_wdata_c <= '0;
    end else if (accept) begin
      bram_we_c    <= validity_mask;
      bram_addr_c  <= wr_addr;
      bram_wdata_c <= inp_data;
    end else begin
      bram_we_c    <= '0;
    end
  end

  // Sticky overrun: set by beats seen in IDLE/DONE, cleared when a new run loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_error <= 1'b0;
    end else if (is_load) begin
      overrun_error <= 1'b0;
    end else if (in_data_available && (state == S_IDLE || state == S_DONE)) begin
      overrun_error <= 1'b1;
    end
  end

  // Done is a pure decode of the registered state.
  always_comb begin
    done_writeback = (state == S_DONE);
  end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: a cycle table for the basic run and mask cases,
// plus hand-written sequences for wrap, gaps, zero-length, abort and mid-run reset.
module tb_result_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [9:0]  address_c;
  logic [9:0]  address_stride_c;
  logic [7:0]  num_vectors;
  logic        in_data_available;
  logic [31:0] inp_data;
  logic [3:0]  validity_mask;
  logic [9:0]  bram_addr_c;
  logic [31:0] bram_wdata_c;
  logic [3:0]  bram_we_c;
  logic        done_writeback;
  logic        overrun_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  result_writeback #(
    .MAT_MUL_SIZE(4),
    .DWIDTH      (8),
    .AWIDTH      (10),
    .MASK_WIDTH  (4),
    .CWIDTH      (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .address_c        (address_c),
    .address_stride_c (address_stride_c),
    .num_vectors      (num_vectors),
    .in_data_available(in_data_available),
    .inp_data         (inp_data),
    .validity_mask    (validity_mask),
    .bram_addr_c      (bram_addr_c),
    .bram_wdata_c     (bram_wdata_c),
    .bram_we_c        (bram_we_c),
    .done_writeback   (done_writeback),
    .overrun_error    (overrun_error)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        ovr;
  } vec_t;

  vec_t tbl [17];

  // Apply inputs, then let one rising edge pass and settle before sampling.
  task automatic step(input logic rst, input logic en, input logic valid,
                      input logic [31:0] data, input logic [3:0] mask);
    reset             = rst;
    enable_writeback  = en;
    in_data_available = valid;
    inp_data          = data;
    validity_mask     = mask;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic done, input logic ovr);
    total++;
    if (bram_we_c !== we || bram_addr_c !== addr || bram_wdata_c !== wdata ||
        done_writeback !== done || overrun_error !== ovr) begin
      bad++;
      $display("FAIL %s: got we=%h addr=%h wdata=%h done=%b ovr=%b, want we=%h addr=%h wdata=%h done=%b ovr=%b",
               name, bram_we_c, bram_addr_c, bram_wdata_c, done_writeback, overrun_error,
               we, addr, wdata, done, ovr);
    end
  endtask

  task automatic cfg(input logic [9:0] a, input logic [9:0] s, input logic [7:0] n);
    address_c        = a;
    address_stride_c = s;
    num_vectors      = n;
  endtask

  initial begin
    //            rst   en    vld   data          mask     we     addr     wdata         done  ovr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0,    4'h0,  10'h000, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h000, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'hA1A1A1A1, 4'hF,    4'hF,  10'h010, 32'hA1A1A1A1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hA2A2A2A2, 4'hF,    4'hF,  10'h014, 32'hA2A2A2A2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'hA3A3A3A3, 4'hF,    4'hF,  10'h018, 32'hA3A3A3A3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hA3A3A3A3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hA3A3A3A3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hA3A3A3A3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hA3A3A3A3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'hB1B1B1B1, 4'b0101, 4'h5,  10'h010, 32'hB1B1B1B1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'hB2B2B2B2, 4'b0000, 4'h0,  10'h014, 32'hB2B2B2B2, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'hB3B3B3B3, 4'hF,    4'hF,  10'h018, 32'hB3B3B3B3, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'hB4B4B4B4, 4'hF,    4'h0,  10'h018, 32'hB3B3B3B3, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hB3B3B3B3, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hB3B3B3B3, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hB3B3B3B3, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        4'h0,    4'h0,  10'h018, 32'hB3B3B3B3, 1'b0, 1'b0};

    reset = 1'b1; enable_writeback = 1'b0; in_data_available = 1'b0;
    inp_data = '0; validity_mask = '0;
    cfg(10'h010, 10'd4, 8'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].data, tbl[i].mask);
      check($sformatf("table_row%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].done, tbl[i].ovr);
    end

    // Address wrap at the top of the BRAM.
    cfg(10'h3FE, 10'd1, 8'd4);
    step(0, 1, 0, 32'h0, 4'h0);
    check("wrap_load", 4'h0, 10'h018, 32'hB3B3B3B3, 0, 0);
    step(0, 1, 1, 32'hC0C0C0C0, 4'hF); check("wrap_3fe", 4'hF, 10'h3FE, 32'hC0C0C0C0, 0, 0);
    step(0, 1, 1, 32'hC1C1C1C1, 4'hF); check("wrap_3ff", 4'hF, 10'h3FF, 32'hC1C1C1C1, 0, 0);
    step(0, 1, 1, 32'hC2C2C2C2, 4'hF); check("wrap_000", 4'hF, 10'h000, 32'hC2C2C2C2, 0, 0);
    step(0, 1, 1, 32'hC3C3C3C3, 4'hF); check("wrap_001", 4'hF, 10'h001, 32'hC3C3C3C3, 1, 0);
    step(0, 0, 0, 32'h0, 4'h0);        check("wrap_idle", 4'h0, 10'h001, 32'hC3C3C3C3, 0, 0);

    // Gapped input: a beat every third cycle, two vectors.
    cfg(10'h100, 10'd8, 8'd2);
    step(0, 1, 0, 32'h0, 4'h0);
    step(0, 1, 1, 32'hD0D0D0D0, 4'hF); check("gap_w0",   4'hF, 10'h100, 32'hD0D0D0D0, 0, 0);
    step(0, 1, 0, 32'h0, 4'h0);        check("gap_idle1", 4'h0, 10'h100, 32'hD0D0D0D0, 0, 0);
    step(0, 1, 0, 32'h0, 4'h0);        check("gap_idle2", 4'h0, 10'h100, 32'hD0D0D0D0, 0, 0);
    step(0, 1, 1, 32'hD1D1D1D1, 4'hF); check("gap_w1",   4'hF, 10'h108, 32'hD1D1D1D1, 1, 0);
    step(0, 1, 0, 32'h0, 4'h0);        check("gap_after", 4'h0, 10'h108, 32'hD1D1D1D1, 1, 0);
    step(0, 0, 0, 32'h0, 4'h0);

    // Zero-length run: done after LOAD with no writes; a beat in DONE is an overrun.
    cfg(10'h020, 10'd1, 8'd0);
    step(0, 1, 0, 32'h0, 4'h0);        check("zero_load", 4'h0, 10'h108, 32'hD1D1D1D1, 0, 0);
    step(0, 1, 0, 32'h0, 4'h0);        check("zero_done", 4'h0, 10'h108, 32'hD1D1D1D1, 1, 0);
    step(0, 1, 1, 32'hEEEEEEEE, 4'hF); check("zero_ovr",  4'h0, 10'h108, 32'hD1D1D1D1, 1, 1);
    step(0, 0, 0, 32'h0, 4'h0);        check("zero_exit", 4'h0, 10'h108, 32'hD1D1D1D1, 0, 1);

    // Abort mid-run: the beat on the abort edge still writes, done never rises.
    cfg(10'h040, 10'd2, 8'd2);
    step(0, 1, 0, 32'h0, 4'h0);        check("abort_load", 4'h0, 10'h108, 32'hD1D1D1D1, 0, 1);
    step(0, 1, 1, 32'hE0E0E0E0, 4'hF); check("abort_w0",   4'hF, 10'h040, 32'hE0E0E0E0, 0, 0);
    step(0, 0, 1, 32'hE1E1E1E1, 4'h3); check("abort_w1",   4'h3, 10'h042, 32'hE1E1E1E1, 0, 0);
    step(0, 0, 0, 32'h0, 4'h0);        check("abort_idle", 4'h0, 10'h042, 32'hE1E1E1E1, 0, 0);

    // Reset during an active run with a beat pending.
    cfg(10'h060, 10'd1, 8'd4);
    step(0, 1, 0, 32'h0, 4'h0);
    step(0, 1, 1, 32'hF0F0F0F0, 4'hF); check("rst_pre",  4'hF, 10'h060, 32'hF0F0F0F0, 0, 0);
    step(0, 1, 1, 32'hF1F1F1F1, 4'hF); check("rst_pre2", 4'hF, 10'h061, 32'hF1F1F1F1, 0, 0);
    step(1, 1, 1, 32'hF2F2F2F2, 4'hF); check("rst_mid",  4'h0, 10'h000, 32'h0, 0, 0);
    step(0, 0, 1, 32'hF3F3F3F3, 4'hF); check("rst_ovr",  4'h0, 10'h000, 32'h0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
